processor_mc: RTL and testbench

Parametrised multi-cycle successor to the single-cycle core. It fetches 32-bit instructions over a request/valid handshake, so instruction memory latency is variable. It decodes a fixed instruction format, executes on a configurable-width register file and ALU, and supports conditional relative branches, a halt instruction and illegal-opcode detection. It sits between the instruction memory and the testbench/debug logic, and replaces the core plus its empty decoder.

---
 rtl/processor_mc.sv | 158 +++++++++++++++
 tb/tb_processor_mc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/processor_mc.sv
// processor_mc: multi-cycle core. It fetches one 32-bit instruction per
// request/valid handshake, decodes the fixed field layout and executes it on
// a DATA_W-wide register file. It supports relative branches, HALT and
// sticky illegal-opcode detection.
module processor_mc #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int NREG   = 32
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_valid,
   input  logic [31:0]       imem_data,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic              illegal,
   output logic [31:0]       instret,
   input  logic [4:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int RIDX = (NREG > 1) ? $clog2(NREG) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_EXEC  = 3'd3;
   localparam logic [2:0] S_HALT  = 3'd4;

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_MUL  = 5'd2;
   localparam logic [4:0] OP_SHL  = 5'd3;
   localparam logic [4:0] OP_AND  = 5'd4;
   localparam logic [4:0] OP_OR   = 5'd5;
   localparam logic [4:0] OP_XOR  = 5'd6;
   localparam logic [4:0] OP_SRL  = 5'd7;
   localparam logic [4:0] OP_HALT = 5'd31;

   logic [2:0]        state;
   logic [31:0]       ir;
   logic [DATA_W-1:0] regs [NREG];

   logic [4:0]        op;
   logic              f_i;
   logic              f_w;
   logic              f_b;
   logic              f_z;
   logic [RIDX-1:0]   dst_idx;
   logic [RIDX-1:0]   src1_idx;
   logic [RIDX-1:0]   src2_idx;
   logic [RIDX-1:0]   dbg_idx;
   logic [DATA_W-1:0] v1;
   logic [DATA_W-1:0] v2;
   logic [DATA_W-1:0] imm_ext;
   logic [DATA_W-1:0] alu_out;
   logic [DATA_W-1:0] t1;
   logic [ADDR_W-1:0] pc_off;
   logic              is_illegal;
   logic              taken;

   assign op       = ir[31:27];
   assign f_i      = ir[26];
   assign f_w      = ir[25];
   assign f_b      = ir[24];
   assign f_z      = ir[23];
   assign dst_idx  = ir[18 +: RIDX];
   assign src1_idx = ir[13 +: RIDX];
   assign src2_idx = ir[8 +: RIDX];
   assign dbg_idx  = dbg_addr[RIDX-1:0];

   assign v1       = regs[src1_idx];
   assign v2       = regs[src2_idx];
   assign dbg_data = regs[dbg_idx];
   assign imm_ext  = DATA_W'($signed(ir[7:0]));

   assign is_illegal = (op > OP_SRL) && (op != OP_HALT);
   assign taken      = f_b && (!f_z || (v1 == '0));
   assign t1         = f_i ? alu_out : imm_ext;
   // The offset is sign-extended so negative branch distances still work when
   // the PC is wider than the datapath.
   assign pc_off     = ADDR_W'($signed(t1));

   assign imem_req  = (state == S_FETCH);
   assign imem_addr = pc;
   assign halted    = (state == S_HALT);

   // ALU: every result wraps to DATA_W bits, and shifts by DATA_W or more clear the value.
   always_comb begin
      alu_out = '0;
      case (op)
         OP_ADD: alu_out = v1 + v2;
         OP_SUB: alu_out = v1 - v2;
         OP_MUL: alu_out = v1 * v2;
         OP_SHL: alu_out = (v2 >= DATA_W'(DATA_W)) ? '0 : (v1 << v2);
         OP_AND: alu_out = v1 & v2;
         OP_OR:  alu_out = v1 | v2;
         OP_XOR: alu_out = v1 ^ v2;
         OP_SRL: alu_out = (v2 >= DATA_W'(DATA_W)) ? '0 : (v1 >> v2);
         default: alu_out = '0;
      endcase
   end

   // Sequencer plus architectural state: fetch handshake, latch, then execute and retire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         pc      <= '0;
         ir      <= '0;
         illegal <= 1'b0;
         instret <= '0;
         for (int k = 0; k < NREG; k++) begin
            regs[k] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               state <= S_FETCH;
            end
            S_FETCH: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_valid) begin
                  ir    <= imem_data;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (op == OP_HALT) begin
                  state <= S_HALT;
               end else begin
                  state   <= S_FETCH;
                  instret <= instret + 32'd1;
                  if (is_illegal) begin
                     illegal <= 1'b1;
                     pc      <= pc + ADDR_W'(1);
                  end else begin
                     if (f_w) begin
                        regs[dst_idx] <= t1;
                     end
                     pc <= taken ? (pc + pc_off) : (pc + ADDR_W'(1));
                  end
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_processor_mc.sv
// tb_processor_mc: directed bench for processor_mc with an 8-bit datapath.
// The bench acts as the instruction memory, serves one instruction per fetch,
// and queues the expected post-execution state for comparison after retirement.
module tb_processor_mc;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [8:0]  imem_addr;
   logic        imem_valid;
   logic [31:0] imem_data;
   logic [8:0]  pc;
   logic        halted;
   logic        illegal;
   logic [31:0] instret;
   logic [4:0]  dbg_addr;
   logic [7:0]  dbg_data;

   typedef struct {
      logic [8:0]  pc;
      logic [31:0] ret;
      logic [7:0]  val;
   } sb_t;

   sb_t  sbq[$];
   int   checks;
   int   errors;
   int   cyc;
   int   last_cyc;
   int   last_lat;
   bit   time_chk;
   logic [8:0] fetch_pc;

   processor_mc #(.DATA_W(8), .ADDR_W(9), .NREG(32)) dut (
      .clk(clk),
      .rst(rst),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_valid(imem_valid),
      .imem_data(imem_data),
      .pc(pc),
      .halted(halted),
      .illegal(illegal),
      .instret(instret),
      .dbg_addr(dbg_addr),
      .dbg_data(dbg_data)
   );

   // Free-running clock and cycle counter.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Hard stop in case the sequence gets stuck somewhere unexpected.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=stuck required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] enc(input logic [4:0] op, input logic i, input logic w,
                                       input logic b, input logic z, input logic [4:0] dst,
                                       input logic [4:0] s1, input logic [4:0] s2,
                                       input logic [7:0] imm);
      return {op, i, w, b, z, dst, s1, s2, imm};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Serve one instruction at the next fetch, after lat WAIT cycles with valid low.
   // Must be called at a negedge. Returns at the negedge following EXEC.
   task automatic applyStimulus(input logic [31:0] instr, input int lat, input bit spurious,
                                input logic [8:0] exp_pc, input logic [31:0] exp_ret,
                                input logic [4:0] dreg, input logic [7:0] old_v,
                                input logic [7:0] new_v);
      sb_t e;
      int  n;
      e.pc  = exp_pc;
      e.ret = exp_ret;
      e.val = new_v;
      sbq.push_back(e);
      dbg_addr = dreg;
      n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (imem_req !== 1'b1) begin
         checkOutput("fetch_timeout", {31'd0, imem_req}, 32'd1);
         void'(sbq.pop_front());
         return;
      end
      checkOutput("fetch_addr", {23'd0, imem_addr}, {23'd0, fetch_pc});
      if (time_chk) checkOutput("instr_cycles", cyc - last_cyc, 3 + last_lat);
      last_cyc = cyc;
      last_lat = lat;
      time_chk = 1'b1;
      if (spurious) begin
         imem_valid = 1'b1;
         imem_data  = 32'hF800_0000;
      end
      @(negedge clk);
      checkOutput("req_one_cycle", {31'd0, imem_req}, 32'd0);
      for (int k = 0; k < lat; k++) begin
         imem_valid = 1'b0;
         @(negedge clk);
      end
      imem_valid = 1'b1;
      imem_data  = instr;
      @(negedge clk);
      imem_valid = 1'b0;
      imem_data  = 32'd0;
      checkOutput("dbg_old", {24'd0, dbg_data}, {24'd0, old_v});
      @(negedge clk);
      e = sbq.pop_front();
      checkOutput("pc", {23'd0, pc}, {23'd0, e.pc});
      checkOutput("instret", instret, e.ret);
      checkOutput("dbg_new", {24'd0, dbg_data}, {24'd0, e.val});
      fetch_pc = e.pc;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      cyc        = 0;
      last_cyc   = 0;
      last_lat   = 0;
      time_chk   = 1'b0;
      fetch_pc   = 9'd0;
      rst        = 1'b1;
      imem_valid = 1'b0;
      imem_data  = 32'd0;
      dbg_addr   = 5'd3;

      // Reset state.
      repeat (2) @(negedge clk);
      checkOutput("rst_pc", {23'd0, pc}, 32'd0);
      checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
      checkOutput("rst_halted", {31'd0, halted}, 32'd0);
      checkOutput("rst_illegal", {31'd0, illegal}, 32'd0);
      checkOutput("rst_instret", instret, 32'd0);
      checkOutput("rst_dbg", {24'd0, dbg_data}, 32'd0);

      // First request appears in the second cycle after release.
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("first_req_c1", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      checkOutput("first_req_c2", {31'd0, imem_req}, 32'd1);

      // r1 <- 5; r2 <- -3; r3 <- r1 + r2
      applyStimulus(enc(5'd0, 0, 1, 0, 0, 5'd1, 5'd0, 5'd0, 8'h05), 0, 0, 9'd1, 32'd1, 5'd1, 8'h00, 8'h05);
      applyStimulus(enc(5'd0, 0, 1, 0, 0, 5'd2, 5'd0, 5'd0, 8'hFD), 0, 0, 9'd2, 32'd2, 5'd2, 8'h00, 8'hFD);
      applyStimulus(enc(5'd0, 1, 1, 0, 0, 5'd3, 5'd1, 5'd2, 8'h00), 0, 0, 9'd3, 32'd3, 5'd3, 8'h00, 8'h02);
      // r5 <- 7; then a taken conditional branch on r4 == 0 from pc 4 back to pc 2
      applyStimulus(enc(5'd0, 0, 1, 0, 0, 5'd5, 5'd0, 5'd0, 8'h07), 0, 0, 9'd4, 32'd4, 5'd5, 8'h00, 8'h07);
      applyStimulus(enc(5'd0, 0, 0, 1, 1, 5'd0, 5'd4, 5'd0, 8'hFE), 0, 0, 9'd2, 32'd5, 5'd4, 8'h00, 8'h00);
      // r1 <- 100; r2 <- 3; same branch on r5 = 7 falls through to pc 5
      applyStimulus(enc(5'd0, 0, 1, 0, 0, 5'd1, 5'd0, 5'd0, 8'h64), 0, 0, 9'd3, 32'd6, 5'd1, 8'h05, 8'h64);
      applyStimulus(enc(5'd0, 0, 1, 0, 0, 5'd2, 5'd0, 5'd0, 8'h03), 0, 0, 9'd4, 32'd7, 5'd2, 8'hFD, 8'h03);
      applyStimulus(enc(5'd0, 0, 0, 1, 1, 5'd0, 5'd5, 5'd0, 8'hFE), 0, 0, 9'd5, 32'd8, 5'd5, 8'h07, 8'h07);
      // r3 <- r1 * r2 wraps to 0x2C; r6 <- 9; r3 <- r1 << r6 clears it
      applyStimulus(enc(5'd2, 1, 1, 0, 0, 5'd3, 5'd1, 5'd2, 8'h00), 0, 0, 9'd6, 32'd9, 5'd3, 8'h02, 8'h2C);
      applyStimulus(enc(5'd0, 0, 1, 0, 0, 5'd6, 5'd0, 5'd0, 8'h09), 0, 0, 9'd7, 32'd10, 5'd6, 8'h00, 8'h09);
      applyStimulus(enc(5'd3, 1, 1, 0, 0, 5'd3, 5'd1, 5'd6, 8'h00), 0, 0, 9'd8, 32'd11, 5'd3, 8'h2C, 8'h00);
      // r8 <- r1 ^ r2; r9 <- r2 - r1 wraps
      applyStimulus(enc(5'd6, 1, 1, 0, 0, 5'd8, 5'd1, 5'd2, 8'h00), 0, 0, 9'd9, 32'd12, 5'd8, 8'h00, 8'h67);
      applyStimulus(enc(5'd1, 1, 1, 0, 0, 5'd9, 5'd2, 5'd1, 8'h00), 0, 0, 9'd10, 32'd13, 5'd9, 8'h00, 8'h9F);
      // Slow memory with a spurious valid during FETCH
      applyStimulus(enc(5'd0, 0, 1, 0, 0, 5'd10, 5'd0, 5'd0, 8'h11), 4, 1, 9'd11, 32'd14, 5'd10, 8'h00, 8'h11);
      applyStimulus(enc(5'd0, 0, 1, 0, 0, 5'd11, 5'd0, 5'd0, 8'h22), 4, 1, 9'd12, 32'd15, 5'd11, 8'h00, 8'h22);
      // Unconditional branch back to pc 511, then +1 wraps to pc 0
      applyStimulus(enc(5'd0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 8'hF3), 0, 0, 9'd511, 32'd16, 5'd0, 8'h00, 8'h00);
      applyStimulus(enc(5'd0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 8'h01), 0, 0, 9'd0, 32'd17, 5'd0, 8'h00, 8'h00);
      checkOutput("illegal_before", {31'd0, illegal}, 32'd0);
      // Opcode 12 with write and branch bits set: neither may take effect
      applyStimulus(enc(5'd12, 0, 1, 1, 0, 5'd1, 5'd0, 5'd0, 8'h55), 0, 0, 9'd1, 32'd18, 5'd1, 8'h64, 8'h64);
      checkOutput("illegal_after", {31'd0, illegal}, 32'd1);

      // Reset in the middle of WAIT
      dbg_addr = 5'd1;
      checkOutput("pre_rst_req", {31'd0, imem_req}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("wrst_pc", {23'd0, pc}, 32'd0);
      checkOutput("wrst_req", {31'd0, imem_req}, 32'd0);
      checkOutput("wrst_illegal", {31'd0, illegal}, 32'd0);
      checkOutput("wrst_instret", instret, 32'd0);
      checkOutput("wrst_dbg", {24'd0, dbg_data}, 32'd0);
      // Late response arrives while reset and IDLE: must be ignored
      imem_valid = 1'b1;
      imem_data  = enc(5'd0, 0, 1, 0, 0, 5'd1, 5'd0, 5'd0, 8'h3C);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("late_req_c1", {31'd0, imem_req}, 32'd0);
      checkOutput("late_dbg", {24'd0, dbg_data}, 32'd0);
      @(negedge clk);
      checkOutput("late_req_c2", {31'd0, imem_req}, 32'd1);
      imem_valid = 1'b0;
      imem_data  = 32'd0;
      time_chk   = 1'b0;
      fetch_pc   = 9'd0;

      // r1 <- 9, then HALT with write bit set
      applyStimulus(enc(5'd0, 0, 1, 0, 0, 5'd1, 5'd0, 5'd0, 8'h09), 0, 0, 9'd1, 32'd1, 5'd1, 8'h00, 8'h09);
      applyStimulus(enc(5'd31, 0, 1, 0, 0, 5'd1, 5'd0, 5'd0, 8'h77), 0, 0, 9'd1, 32'd1, 5'd1, 8'h09, 8'h09);
      checkOutput("halted", {31'd0, halted}, 32'd1);
      repeat (4) @(negedge clk);
      checkOutput("halt_req", {31'd0, imem_req}, 32'd0);
      checkOutput("halt_pc", {23'd0, pc}, 32'd1);
      checkOutput("halt_instret", instret, 32'd1);
      checkOutput("halt_stays", {31'd0, halted}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
